btb_ctrl: RTL and testbench
===========================

// Module: btb_ctrl
// PURPOSE
//  Sequencer/arbiter for the single-port BTB (tag+data mem, 1-cycle read latency).
//  Shares the port between fetch lookups and buffered execute-stage updates.
//  Walks every entry to invalidate it after reset and on flush (fence.i / context change).
//  Sits between the IF stage, the EX/branch-resolve unit and the btb instance.
// PARAMETERS
//  TAG_DEPTH    1024  BTB entries; IDX_W = $clog2(TAG_DEPTH)
//  GROUP_WIDTH  1     low pc bits above bit 0 skipped in index; index = pc[(1+GROUP_WIDTH)+:IDX_W]
//  UPD_DEPTH    4     update FIFO entries (power of 2, >=2)
//  STARVE_MAX   7     consecutive lookup grants while FIFO non-empty before a write is forced
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   synchronous reset, active low
//  lkp_req       in   1   fetch requests lookup of lkp_pc
//  lkp_pc        in   31  [31:1] lookup pc
//  lkp_gnt       out  1   lookup issued to BTB this cycle
//  lkp_rvalid    out  1   result valid (cycle after lkp_gnt)
//  lkp_hit       out  1   BTB hit for granted lookup
//  lkp_target    out  31  [31:1] predicted target
//  upd_valid     in   1   update request
//  upd_ready     out  1   FIFO can accept
//  upd_invalid   in   1   1 = invalidate entry, 0 = install
//  upd_pc        in   31  [31:1] branch pc
//  upd_target    in   32  resolved target
//  flush_req     in   1   start full invalidate walk
//  flush_busy    out  1   INIT or FLUSH walk in progress
//  btb_rd        out  1   to btb
//  pc_r          out  31  to btb
//  btb_hit       in   1   from btb
//  target_pc_r   in   31  from btb
//  btb_wr        out  1   to btb
//  btb_invalid   out  1   to btb
//  pc_w          out  31  to btb
//  target_pc_w   out  32  to btb
// BEHAVIOUR
//  Reset: state=INIT, walk_idx=0, FIFO empty, starve_cnt=0; all outputs 0 except flush_busy=1.
//  States: INIT, RUN, FLUSH. btb_rd and btb_wr are never high in the same cycle.
//  INIT/FLUSH: each cycle btb_wr=1, btb_invalid=1, pc_w index field=walk_idx, other pc_w bits 0,
//   target_pc_w=0; walk_idx++ ; after idx TAG_DEPTH-1 -> RUN, walk_idx=0. Walk = TAG_DEPTH cycles.
//   upd_ready=0, lkp_gnt=0, flush_busy=1.
//  RUN -> FLUSH on flush_req: FIFO cleared same edge, walk starts next cycle.
//   flush_req in INIT/FLUSH restarts walk_idx at 0.
//  RUN arbitration: write_sel = fifo_nempty & (!lkp_req | fifo_full | starve_cnt==STARVE_MAX).
//   write_sel: pop FIFO head -> btb_wr=1, pc_w/target_pc_w/btb_invalid from head.
//   else lkp_req: btb_rd=1, pc_r=lkp_pc, lkp_gnt=1.
//   starve_cnt: ++ on lookup grant while FIFO non-empty; 0 on write or FIFO empty; saturates.
//  Lookup result: lkp_rvalid = registered lkp_gnt; lkp_hit = btb_hit & lkp_rvalid,
//   forced 0 if FLUSH entered on the grant edge; lkp_target = target_pc_r passthrough.
//  FIFO: upd_ready = RUN & !full; push on upd_valid&upd_ready. Push+pop same cycle when full is
//   not allowed (ready=0 when full); push+pop when non-full keeps count. No forwarding of queued
//   updates to lookups; stale prediction is acceptable.
//  Same-pc updates retire in order; last write wins.
// STRUCTURE
//  btb_pkg: btb_ctrl_state_e {INIT,RUN,FLUSH}, btb_upd_t {invalid, pc[31:1], target[31:0]},
//   index-extract function.
//  Sub-module btb_upd_fifo (sync FIFO of btb_upd_t, UPD_DEPTH, full/empty/flush).
// TESTING
//  1 reset release -> 1024 writes btb_invalid=1, pc_w idx 0..1023, flush_busy falls at cycle 1024.
//  2 RUN, FIFO empty, lkp_req pc=0x100 -> lkp_gnt same cycle, lkp_rvalid next; hit mirrors btb_hit.
//  3 continuous lkp_req + 1 update -> write issued exactly on 8th grant slot (STARVE_MAX=7).
//  4 4 updates, lkp_req held high -> upd_ready=0 on full; next cycle btb_wr=1, lookup stalled.
//  5 flush_req with 3 queued updates -> queued updates never written; 1024-cycle walk; upd_ready=0.
//  6 install pc=0x200 target 0x8000_0040, drain, lookup 0x200 -> btb_wr fields match, hit reported.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and pc/index helpers for the BTB port controller and its update queue.
package btb_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } btb_ctrl_state_e;

    typedef struct packed {
        logic        invalid;
        logic [31:1] pc;
        logic [31:0] target;
    } btb_upd_t;

    // Index field of a [31:1] pc, right-aligned; the caller keeps the low IDX_W bits.
    function automatic logic [30:0] btb_index(input logic [31:1] pc, input int unsigned group_width);
        return pc >> group_width;
    endfunction

    // Inverse of btb_index: places an index into the pc field, all other bits zero.
    function automatic logic [31:1] btb_index_pc(input logic [30:0] idx, input int unsigned group_width);
        return idx << group_width;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO holding execute-stage BTB updates until the shared port is free.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     flush,
    input  logic     push,
    input  btb_upd_t push_data,
    input  logic     pop,
    output btb_upd_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    btb_upd_t    mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;

    // Read/write pointers with a wrap bit; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = ((wr_ptr_r ^ rd_ptr_r) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/btb_ctrl.sv
// Single-port BTB sequencer: invalidate walks, fetch lookups and queued EX-stage updates
// share one port, with a starvation limit so queued writes always make progress.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned TAG_DEPTH   = 1024,
    parameter int unsigned GROUP_WIDTH = 1,
    parameter int unsigned UPD_DEPTH   = 4,
    parameter int unsigned STARVE_MAX  = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lkp_req,
    input  logic [31:1] lkp_pc,
    output logic        lkp_gnt,
    output logic        lkp_rvalid,
    output logic        lkp_hit,
    output logic [31:1] lkp_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic        upd_invalid,
    input  logic [31:1] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        btb_rd,
    output logic [31:1] pc_r,
    input  logic        btb_hit,
    input  logic [31:1] target_pc_r,
    output logic        btb_wr,
    output logic        btb_invalid,
    output logic [31:1] pc_w,
    output logic [31:0] target_pc_w
);

    localparam int unsigned       IDX_W    = $clog2(TAG_DEPTH);
    localparam int unsigned       CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W - 1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(TAG_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_MAX);

    btb_ctrl_state_e  state_r, state_s;
    logic [IDX_W-1:0] walk_idx_r, walk_idx_s;
    logic [CNT_W-1:0] starve_cnt_r, starve_cnt_s;
    logic             lkp_rvalid_r;
    logic             hit_kill_r;
    logic             write_sel_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    btb_upd_t         fifo_head_s;
    btb_upd_t         push_data_s;

    assign push_s      = upd_valid & upd_ready;
    assign push_data_s = '{invalid: upd_invalid, pc: upd_pc, target: upd_target};

    btb_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush_req),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (write_sel_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next-state, port arbitration and BTB port drive.
    always_comb begin
        state_s      = state_r;
        walk_idx_s   = walk_idx_r;
        starve_cnt_s = starve_cnt_r;
        write_sel_s  = 1'b0;
        lkp_gnt      = 1'b0;
        btb_rd       = 1'b0;
        pc_r         = 31'd0;
        btb_wr       = 1'b0;
        btb_invalid  = 1'b0;
        pc_w         = 31'd0;
        target_pc_w  = 32'd0;
        upd_ready    = 1'b0;
        flush_busy   = 1'b0;
        case (state_r)
            INIT, FLUSH: begin
                flush_busy   = 1'b1;
                starve_cnt_s = CNT_ZERO;
                // Port stays quiet while reset is held; the walk begins on release.
                if (reset_n) begin
                    btb_wr      = 1'b1;
                    btb_invalid = 1'b1;
                    pc_w        = btb_index_pc(31'(walk_idx_r), GROUP_WIDTH);
                end else begin
                    btb_wr      = 1'b0;
                end
                if (flush_req) begin
                    walk_idx_s = IDX_ZERO;
                end else if (walk_idx_r == IDX_LAST) begin
                    state_s    = RUN;
                    walk_idx_s = IDX_ZERO;
                end else begin
                    walk_idx_s = walk_idx_r + IDX_ONE;
                end
            end
            RUN: begin
                upd_ready   = !fifo_full_s;
                // Queued writes are dropped on flush, so never issue one on the flush edge.
                write_sel_s = !fifo_empty_s && !flush_req &&
                              (!lkp_req || fifo_full_s || (starve_cnt_r == CNT_MAX));
                if (write_sel_s) begin
                    btb_wr      = 1'b1;
                    btb_invalid = fifo_head_s.invalid;
                    pc_w        = fifo_head_s.pc;
                    target_pc_w = fifo_head_s.target;
                end else if (lkp_req) begin
                    lkp_gnt = 1'b1;
                    btb_rd  = 1'b1;
                    pc_r    = lkp_pc;
                end else begin
                    lkp_gnt = 1'b0;
                end
                if (flush_req || write_sel_s || fifo_empty_s) begin
                    starve_cnt_s = CNT_ZERO;
                end else if (lkp_gnt && (starve_cnt_r != CNT_MAX)) begin
                    starve_cnt_s = starve_cnt_r + CNT_ONE;
                end else begin
                    starve_cnt_s = starve_cnt_r;
                end
                if (flush_req) begin
                    state_s    = FLUSH;
                    walk_idx_s = IDX_ZERO;
                end else begin
                    state_s    = RUN;
                end
            end
            default: begin
                state_s    = INIT;
                walk_idx_s = IDX_ZERO;
                flush_busy = 1'b1;
            end
        endcase
    end

    // State, walk index, starvation count and lookup-result pipeline registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= INIT;
            walk_idx_r   <= IDX_ZERO;
            starve_cnt_r <= CNT_ZERO;
            lkp_rvalid_r <= 1'b0;
            hit_kill_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            walk_idx_r   <= walk_idx_s;
            starve_cnt_r <= starve_cnt_s;
            lkp_rvalid_r <= lkp_gnt;
            hit_kill_r   <= lkp_gnt & flush_req;
        end
    end

    // A hit read on the flush edge refers to an entry the walk is about to erase.
    assign lkp_rvalid = lkp_rvalid_r;
    assign lkp_hit    = btb_hit & lkp_rvalid_r & ~hit_kill_r;
    assign lkp_target = target_pc_r;

endmodule

// File: tb/tb_btb_ctrl.sv
// Scoreboard bench for btb_ctrl: a queue-based reference model plus a behavioural BTB memory.
module tb_btb_ctrl;

    localparam int TAG_DEPTH  = 1024;
    localparam int UPD_DEPTH  = 4;
    localparam int STARVE_MAX = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lkp_req, lkp_gnt, lkp_rvalid, lkp_hit;
    logic [30:0] lkp_pc, lkp_target;
    logic        upd_valid, upd_ready, upd_invalid;
    logic [30:0] upd_pc;
    logic [31:0] upd_target;
    logic        flush_req, flush_busy;
    logic        btb_rd, btb_hit, btb_wr, btb_invalid;
    logic [30:0] pc_r, target_pc_r, pc_w;
    logic [31:0] target_pc_w;

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .lkp_req(lkp_req), .lkp_pc(lkp_pc), .lkp_gnt(lkp_gnt), .lkp_rvalid(lkp_rvalid),
        .lkp_hit(lkp_hit), .lkp_target(lkp_target),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_invalid(upd_invalid),
        .upd_pc(upd_pc), .upd_target(upd_target),
        .flush_req(flush_req), .flush_busy(flush_busy),
        .btb_rd(btb_rd), .pc_r(pc_r), .btb_hit(btb_hit), .target_pc_r(target_pc_r),
        .btb_wr(btb_wr), .btb_invalid(btb_invalid), .pc_w(pc_w), .target_pc_w(target_pc_w)
    );

    // Behavioural BTB: full-pc tag, index = byte address bits [11:2], 1-cycle read.
    logic        mem_valid [TAG_DEPTH];
    logic [30:0] mem_tag   [TAG_DEPTH];
    logic [31:0] mem_tgt   [TAG_DEPTH];
    always @(posedge clk) begin
        if (!reset_n) begin
            btb_hit     <= 1'b0;
            target_pc_r <= 31'd0;
        end else begin
            if (btb_wr) begin
                mem_valid[pc_w[10:1]] <= !btb_invalid;
                mem_tag[pc_w[10:1]]   <= pc_w;
                mem_tgt[pc_w[10:1]]   <= target_pc_w;
            end
            if (btb_rd) begin
                btb_hit     <= mem_valid[pc_r[10:1]] && (mem_tag[pc_r[10:1]] == pc_r);
                target_pc_r <= mem_tgt[pc_r[10:1]][31:1];
            end
        end
    end

    typedef struct { int cyc; bit inv; logic [30:0] pc; logic [31:0] tgt; } wr_t;
    typedef struct { int cyc; bit hit; logic [30:0] tgt; } lk_t;
    typedef struct { int cyc; bit gnt; logic [30:0] rpc; bit ready; bit busy; } ctl_t;
    typedef struct { bit inv; logic [31:0] addr; logic [31:0] tgt; } upd_t;

    wr_t  wr_q[$];
    lk_t  lk_q[$];
    ctl_t ctl_q[$];
    upd_t m_fifo[$];
    bit          m_walking;
    int          m_walk, m_starve;
    bit          t_valid [TAG_DEPTH];
    logic [31:0] t_addr  [TAG_DEPTH];
    logic [31:0] t_tgt   [TAG_DEPTH];

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 2) % TAG_DEPTH);
    endfunction

    // One clock of stimulus; the model predicts this cycle's port activity and next-cycle results.
    task automatic step(input bit lr, input logic [31:0] la, input bit uv, input bit ui,
                        input logic [31:0] ua, input logic [31:0] ut, input bit fl);
        ctl_t c; wr_t w; lk_t l; upd_t u;
        bit full, ne, wsel;
        int idx;
        lkp_req = lr; lkp_pc = la[31:1];
        upd_valid = uv; upd_invalid = ui; upd_pc = ua[31:1]; upd_target = ut;
        flush_req = fl;
        c.cyc = cyc; c.gnt = 1'b0; c.rpc = la[31:1];
        if (m_walking) begin
            c.ready = 1'b0; c.busy = 1'b1;
            w.cyc = cyc; w.inv = 1'b1; w.pc = 31'(m_walk * 2); w.tgt = 32'd0;
            wr_q.push_back(w);
            t_valid[m_walk] = 1'b0;
            m_starve = 0;
            if (fl) m_walk = 0;
            else if (m_walk == TAG_DEPTH - 1) begin m_walking = 1'b0; m_walk = 0; end
            else m_walk++;
        end else begin
            full = (m_fifo.size() == UPD_DEPTH);
            ne   = (m_fifo.size() > 0);
            c.ready = !full; c.busy = 1'b0;
            wsel = ne && !fl && (!lr || full || m_starve == STARVE_MAX);
            if (wsel) begin
                u = m_fifo.pop_front();
                w.cyc = cyc; w.inv = u.inv; w.pc = u.addr[31:1]; w.tgt = u.tgt;
                wr_q.push_back(w);
                idx = idx_of(u.addr);
                t_valid[idx] = !u.inv; t_addr[idx] = u.addr; t_tgt[idx] = u.tgt;
            end else if (lr) begin
                c.gnt = 1'b1;
                idx = idx_of(la);
                l.cyc = cyc + 1;
                l.hit = t_valid[idx] && (t_addr[idx] == la) && !fl;
                l.tgt = t_tgt[idx][31:1];
                lk_q.push_back(l);
            end
            if (wsel || !ne || fl) m_starve = 0;
            else if (c.gnt && m_starve < STARVE_MAX) m_starve++;
            if (uv && !full) begin
                u.inv = ui; u.addr = ua; u.tgt = ut;
                m_fifo.push_back(u);
            end
            if (fl) begin m_fifo.delete(); m_walking = 1'b1; m_walk = 0; end
        end
        ctl_q.push_back(c);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 12) |
               (32'($urandom_range(0, 3) == 0) << 1);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a port action or result.
    always @(negedge clk) begin
        if (mon_en) begin
            ctl_t c; wr_t w; lk_t l;
            if (ctl_q.size() == 0) chk(1'b0, "ctl_underflow", 64'd0, 64'd1);
            else begin
                c = ctl_q.pop_front();
                chk(c.cyc == cyc, "ctl_cycle", 64'(cyc), 64'(c.cyc));
                chk(lkp_gnt == c.gnt, "lkp_gnt", 64'(lkp_gnt), 64'(c.gnt));
                chk(btb_rd == c.gnt, "btb_rd", 64'(btb_rd), 64'(c.gnt));
                if (c.gnt) chk(pc_r == c.rpc, "pc_r", 64'(pc_r), 64'(c.rpc));
                chk(upd_ready == c.ready, "upd_ready", 64'(upd_ready), 64'(c.ready));
                chk(flush_busy == c.busy, "flush_busy", 64'(flush_busy), 64'(c.busy));
            end
            if (btb_wr) begin
                if (wr_q.size() == 0) chk(1'b0, "wr_spurious", 64'(pc_w), 64'd0);
                else begin
                    w = wr_q.pop_front();
                    chk(w.cyc == cyc, "wr_cycle", 64'(cyc), 64'(w.cyc));
                    chk(btb_invalid == w.inv, "btb_invalid", 64'(btb_invalid), 64'(w.inv));
                    chk(pc_w == w.pc, "pc_w", 64'(pc_w), 64'(w.pc));
                    chk(target_pc_w == w.tgt, "target_pc_w", 64'(target_pc_w), 64'(w.tgt));
                end
            end
            if (lkp_rvalid) begin
                if (lk_q.size() == 0) chk(1'b0, "rvalid_spurious", 64'd1, 64'd0);
                else begin
                    l = lk_q.pop_front();
                    chk(l.cyc == cyc, "rvalid_cycle", 64'(cyc), 64'(l.cyc));
                    chk(lkp_hit == l.hit, "lkp_hit", 64'(lkp_hit), 64'(l.hit));
                    if (l.hit) chk(lkp_target == l.tgt, "lkp_target", 64'(lkp_target), 64'(l.tgt));
                end
            end else begin
                chk(lkp_hit == 1'b0, "lkp_hit_idle", 64'(lkp_hit), 64'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < TAG_DEPTH; i++) begin
            t_valid[i] = 1'b0; t_addr[i] = 32'd0; t_tgt[i] = 32'd0; mem_valid[i] = 1'b0;
        end
        reset_n = 1'b0; lkp_req = 1'b0; lkp_pc = 31'd0; upd_valid = 1'b0; upd_invalid = 1'b0;
        upd_pc = 31'd0; upd_target = 32'd0; flush_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(flush_busy == 1'b1, "rst_flush_busy", 64'(flush_busy), 64'd1);
        chk(btb_wr == 1'b0, "rst_btb_wr", 64'(btb_wr), 64'd0);
        chk(btb_rd == 1'b0, "rst_btb_rd", 64'(btb_rd), 64'd0);
        chk(lkp_gnt == 1'b0, "rst_lkp_gnt", 64'(lkp_gnt), 64'd0);
        chk(upd_ready == 1'b0, "rst_upd_ready", 64'(upd_ready), 64'd0);
        chk(lkp_rvalid == 1'b0, "rst_lkp_rvalid", 64'(lkp_rvalid), 64'd0);
        chk(btb_invalid == 1'b0, "rst_btb_invalid", 64'(btb_invalid), 64'd0);

        reset_n = 1'b1; m_walking = 1'b1; m_walk = 0; m_starve = 0; mon_en = 1'b1;
        idle(1030);
        // single lookup on an empty table
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(3);
        // one update against continuous lookups: write on the 8th slot
        step(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 32'h1234_5678, 1'b0);
        repeat (12) step(1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(2);
        // fill the FIFO while lookups keep coming
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h100, 1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
        repeat (10) step(1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        // three queued updates then flush with a hitting lookup on the flush edge
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h108, 1'b1, 1'b0, 32'h500 + 32'(i * 4), 32'hB000_0000, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(1030);
        // install, drain, look up
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'h200, 32'h8000_0040, 1'b0);
        idle(2);
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, rand_pc(), $urandom_range(0, 9) < 4,
                 $urandom_range(0, 3) == 0, rand_pc(), $urandom, $urandom_range(0, 499) == 0);
        idle(1030);
        mon_en = 1'b0;
        chk((wr_q.size() == 0) && (lk_q.size() == 0) && (ctl_q.size() == 0), "queues_drained",
            64'(wr_q.size() + lk_q.size() + ctl_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
